// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and client IDs for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WDATA} arb_state_t;
  localparam logic CLIENT_IC = 1'b0;
  localparam logic CLIENT_DC = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker; on a tie the client not granted last wins.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);
  always_comb begin
    grant = &valid ? ~last : valid[1];
    any   = |valid;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request/data/response port between icache and dcache.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int TAG_W  = 5,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic                ic_req_rw,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  input  logic [TAG_W-2:0]    ic_req_tag,
  input  logic                ic_data_valid,
  output logic                ic_data_ready,
  input  logic [DATA_W-1:0]   ic_data_bits,
  input  logic [DATA_W/8-1:0] ic_data_mask,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,
  output logic [TAG_W-2:0]    ic_resp_tag,
  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [TAG_W-2:0]    dc_req_tag,
  input  logic                dc_data_valid,
  output logic                dc_data_ready,
  input  logic [DATA_W-1:0]   dc_data_bits,
  input  logic [DATA_W/8-1:0] dc_data_mask,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,
  output logic [TAG_W-2:0]    dc_resp_tag,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [TAG_W-1:0]    mem_req_tag,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  input  logic [TAG_W-1:0]    mem_resp_tag
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          pick_grant, pick_any;
  logic          owner_dc, in_req, in_wd, last_beat, data_hs;

  rr_pick2 u_pick (
    .valid ({dc_req_valid, ic_req_valid}),
    .last  (last_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  assign owner_dc  = owner_q == CLIENT_DC;
  assign in_req    = state_q == ARB_REQ;
  assign in_wd     = state_q == ARB_WDATA;
  assign last_beat = beat_q == BW'(BEATS - 1);
  assign data_hs   = mem_req_data_valid & mem_req_data_ready;

  assign mem_req_valid = in_req;
  assign mem_req_rw    = owner_dc ? dc_req_rw : ic_req_rw;
  assign mem_req_addr  = owner_dc ? dc_req_addr : ic_req_addr;
  assign mem_req_tag   = {owner_q, owner_dc ? dc_req_tag : ic_req_tag};
  assign ic_req_ready  = in_req & ~owner_dc & mem_req_ready;
  assign dc_req_ready  = in_req & owner_dc & mem_req_ready;

  assign mem_req_data_valid = in_wd & (owner_dc ? dc_data_valid : ic_data_valid);
  assign mem_req_data_bits  = owner_dc ? dc_data_bits : ic_data_bits;
  assign mem_req_data_mask  = owner_dc ? dc_data_mask : ic_data_mask;
  assign ic_data_ready      = in_wd & ~owner_dc & mem_req_data_ready;
  assign dc_data_ready      = in_wd & owner_dc & mem_req_data_ready;

  // Responses are routed purely by the client-ID tag bit, independent of FSM state.
  assign ic_resp_valid = mem_resp_valid & ~mem_resp_tag[TAG_W-1];
  assign dc_resp_valid = mem_resp_valid & mem_resp_tag[TAG_W-1];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;
  assign ic_resp_tag   = mem_resp_tag[TAG_W-2:0];
  assign dc_resp_tag   = mem_resp_tag[TAG_W-2:0];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      ARB_IDLE: if (pick_any) begin
        owner_d = pick_grant;
        state_d = ARB_REQ;
      end
      ARB_REQ: if (mem_req_ready) begin
        last_d  = owner_q;
        beat_d  = '0;
        state_d = mem_req_rw ? ARB_WDATA : ARB_IDLE;
      end
      ARB_WDATA: if (data_hs) begin
        beat_d  = last_beat ? '0 : beat_q + 1'b1;
        state_d = last_beat ? ARB_IDLE : ARB_WDATA;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= CLIENT_IC;
      last_q  <= CLIENT_DC;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic ic_req_valid, ic_req_ready, ic_req_rw, ic_data_valid, ic_data_ready, ic_resp_valid;
  logic [27:0] ic_req_addr;
  logic [3:0] ic_req_tag, ic_resp_tag;
  logic [127:0] ic_data_bits, ic_resp_data;
  logic [15:0] ic_data_mask;
  logic dc_req_valid, dc_req_ready, dc_req_rw, dc_data_valid, dc_data_ready, dc_resp_valid;
  logic [27:0] dc_req_addr;
  logic [3:0] dc_req_tag, dc_resp_tag;
  logic [127:0] dc_data_bits, dc_resp_data;
  logic [15:0] dc_data_mask;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
  logic [27:0] mem_req_addr;
  logic [4:0] mem_req_tag, mem_resp_tag;
  logic [127:0] mem_req_data_bits, mem_resp_data;
  logic [15:0] mem_req_data_mask;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_rw(ic_req_rw),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag), .ic_data_valid(ic_data_valid),
    .ic_data_ready(ic_data_ready), .ic_data_bits(ic_data_bits), .ic_data_mask(ic_data_mask),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_tag(ic_resp_tag),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag), .dc_data_valid(dc_data_valid),
    .dc_data_ready(dc_data_ready), .dc_data_bits(dc_data_bits), .dc_data_mask(dc_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_tag(dc_resp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_rw = 0; ic_req_addr = '0; ic_req_tag = '0;
    ic_data_valid = 0; ic_data_bits = '0; ic_data_mask = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_tag = '0;
    dc_data_valid = 0; dc_data_bits = '0; dc_data_mask = '0;
    mem_req_ready = 1; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 0; clear_inputs();
    @(negedge clk); reset = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ic_req_valid = 1; dc_req_valid = 1;
    mem_resp_valid = 1; mem_resp_tag = 5'h15; mem_resp_data = 128'h1234;
    @(negedge clk); #1;
    n_chk++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %0b exp 0", mem_req_valid); end
    n_chk++; if ({ic_req_ready, dc_req_ready, ic_data_ready, dc_data_ready} !== 4'b0) begin n_fail++; $display("FAIL rst_readys got %b exp 0000", {ic_req_ready, dc_req_ready, ic_data_ready, dc_data_ready}); end
    n_chk++; if ({dc_resp_valid, ic_resp_valid, dc_resp_tag} !== 6'b10_0101) begin n_fail++; $display("FAIL rst_resp_route got %b exp 100101", {dc_resp_valid, ic_resp_valid, dc_resp_tag}); end
    clear_inputs();
    reset = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h0000040; ic_req_tag = 4'd3;
    #1;
    n_chk++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency got %0b exp 0", mem_req_valid); end
    @(negedge clk); #1;
    n_chk++; if ({mem_req_valid, mem_req_rw, mem_req_tag} !== 7'b10_00011) begin n_fail++; $display("FAIL rd_req got %b exp 1000011", {mem_req_valid, mem_req_rw, mem_req_tag}); end
    n_chk++; if (mem_req_addr !== 28'h0000040) begin n_fail++; $display("FAIL rd_addr got %h exp 0000040", mem_req_addr); end
    n_chk++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin n_fail++; $display("FAIL rd_ready got %b exp 10", {ic_req_ready, dc_req_ready}); end
    @(negedge clk);
    ic_req_valid = 0;
    mem_resp_valid = 1; mem_resp_tag = 5'h03; mem_resp_data = 128'hCAFE_F00D;
    #1;
    n_chk++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_back_idle got %0b exp 0", mem_req_valid); end
    n_chk++; if ({ic_resp_valid, dc_resp_valid, ic_resp_tag} !== 6'b10_0011) begin n_fail++; $display("FAIL rd_resp got %b exp 100011", {ic_resp_valid, dc_resp_valid, ic_resp_tag}); end
    n_chk++; if (ic_resp_data !== 128'hCAFE_F00D) begin n_fail++; $display("FAIL rd_resp_data got %h exp cafef00d", ic_resp_data); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [3:0] order = 4'b1010;
    do_reset();
    @(negedge clk);
    ic_req_valid = 1; ic_req_addr = 28'h100; ic_req_tag = 4'd1;
    dc_req_valid = 1; dc_req_addr = 28'h200; dc_req_tag = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_chk++; if ({mem_req_valid, mem_req_tag} !== {1'b1, order[i] ? 5'h12 : 5'h01}) begin n_fail++; $display("FAIL b2b_grant%0d got %b exp %b", i, {mem_req_valid, mem_req_tag}, {1'b1, order[i] ? 5'h12 : 5'h01}); end
      n_chk++; if (mem_req_addr !== (order[i] ? 28'h200 : 28'h100)) begin n_fail++; $display("FAIL b2b_addr%0d got %h", i, mem_req_addr); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_dc_write_stall();
    logic [5:0] rdy = 6'b110011;
    int b = 0, hs = 0;
    @(negedge clk);
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0ABCDE0; dc_req_tag = 4'd5;
    @(negedge clk); #1;
    n_chk++; if ({mem_req_valid, mem_req_rw, mem_req_tag, dc_req_ready} !== 8'b11_10101_1) begin n_fail++; $display("FAIL wr_req got %b exp 11101011", {mem_req_valid, mem_req_rw, mem_req_tag, dc_req_ready}); end
    ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h300; ic_req_tag = 4'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dc_req_valid = 0; dc_data_valid = 1; dc_data_mask = 16'hF0F3;
      dc_data_bits = 128'(32'hDA7A0000 + b); mem_req_data_ready = rdy[i];
      #1;
      n_chk++; if ({mem_req_data_valid, mem_req_valid, ic_data_ready, dc_data_ready} !== {3'b100, rdy[i]}) begin n_fail++; $display("FAIL wr_beat%0d got %b exp %b", i, {mem_req_data_valid, mem_req_valid, ic_data_ready, dc_data_ready}, {3'b100, rdy[i]}); end
      n_chk++; if ({mem_req_data_mask, mem_req_data_bits} !== {16'hF0F3, 128'(32'hDA7A0000 + b)}) begin n_fail++; $display("FAIL wr_data%0d got %h/%h", i, mem_req_data_mask, mem_req_data_bits); end
      if (mem_req_data_valid && mem_req_data_ready) hs++;
      if (rdy[i]) b++;
    end
    @(negedge clk);
    dc_data_valid = 0; mem_req_data_ready = 0;
    #1;
    n_chk++; if (hs !== 4) begin n_fail++; $display("FAIL wr_handshakes got %0d exp 4", hs); end
    n_chk++; if ({mem_req_data_valid, mem_req_valid} !== 2'b00) begin n_fail++; $display("FAIL wr_done got %b exp 00", {mem_req_data_valid, mem_req_valid}); end
    @(negedge clk); #1;
    n_chk++; if ({mem_req_valid, mem_req_tag} !== 6'b1_01001) begin n_fail++; $display("FAIL wr_ic_after got %b exp 101001", {mem_req_valid, mem_req_tag}); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_resp_during_write();
    @(negedge clk);
    dc_req_valid = 1; dc_req_rw = 1; dc_req_tag = 4'd6;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dc_req_valid = 0; dc_data_valid = 1; mem_req_data_ready = 1; dc_data_bits = 128'(i);
      mem_resp_valid = (i == 1); mem_resp_tag = 5'h12; mem_resp_data = 128'hBEEF;
      #1;
      n_chk++; if ({mem_req_data_valid, dc_data_ready, mem_req_data_bits[1:0]} !== {2'b11, 2'(i)}) begin n_fail++; $display("FAIL rdw_beat%0d got %b", i, {mem_req_data_valid, dc_data_ready, mem_req_data_bits[1:0]}); end
      n_chk++; if ({dc_resp_valid, ic_resp_valid} !== {i == 1, 1'b0}) begin n_fail++; $display("FAIL rdw_resp%0d got %b exp %b", i, {dc_resp_valid, ic_resp_valid}, {i == 1, 1'b0}); end
      if (i == 1) begin
        n_chk++; if ({dc_resp_tag, dc_resp_data} !== {4'd2, 128'hBEEF}) begin n_fail++; $display("FAIL rdw_resp_tag got %h/%h exp 2/beef", dc_resp_tag, dc_resp_data); end
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_chk++; if (mem_req_data_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_end got %0b exp 0", mem_req_data_valid); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    dc_req_valid = 1; dc_req_rw = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dc_req_valid = 0; dc_data_valid = 1; mem_req_data_ready = 1;
    end
    @(negedge clk);
    reset = 0;
    #1;
    n_chk++; if ({mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready, ic_data_ready, dc_data_ready} !== 6'b0) begin n_fail++; $display("FAIL rmw_outputs got %b exp 000000", {mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready, ic_data_ready, dc_data_ready}); end
    clear_inputs();
    @(negedge clk); reset = 1;
    @(negedge clk);
    ic_req_valid = 1; ic_req_tag = 4'd7; dc_req_valid = 1; dc_req_tag = 4'd8;
    @(negedge clk); #1;
    n_chk++; if ({mem_req_valid, mem_req_tag, ic_req_ready, dc_req_ready, mem_req_data_valid} !== 9'b1_00111_100) begin n_fail++; $display("FAIL rmw_fresh got %b exp 100111100", {mem_req_valid, mem_req_tag, ic_req_ready, dc_req_ready, mem_req_data_valid}); end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_dc_write_stall();
    test_resp_during_write();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
